led_feedback_driver: RTL and testbench
======================================

LED_FEEDBACK_DRIVER -- requirements
Module: led_feedback_driver

Interface
REQ-001 Parameter: CNT_W, 16, width of the timing counter.
REQ-002 Parameter: HIT_CYCLES, 65535, LED-on duration for a hit; legal range 1..2^CNT_W-1.
REQ-003 Parameter: BLINK_CYCLES, 16384, duration of each on phase and each off phase of a miss blink; legal range 1..2^CNT_W-1.
REQ-004 Parameter: MISS_BLINKS, 3, number of on/off pairs per miss; legal range 1..15.
REQ-005 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-006 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port: hit  input  1  synchronous single-cycle strobe requesting a hit indication.
REQ-008 Port: miss  input  1  synchronous single-cycle strobe requesting a miss indication.
REQ-009 Port: led_n  output  1  active-low LED drive; 0 means LED lit.
REQ-010 Port: busy  output  1  1 while any indication is in progress.
REQ-011 Port: done  output  1  single-cycle pulse when an indication completes.

Function
REQ-012 The block SHALL implement the states IDLE, HIT_ON, MISS_ON and MISS_OFF.
REQ-013 Outputs SHALL be registered: led_n = 0 only in HIT_ON and MISS_ON; busy = 1 in every state except IDLE.
REQ-014 IDLE + miss SHALL go to MISS_ON on the next edge, with the counter and blink count cleared.
REQ-015 IDLE + hit with no miss SHALL go to HIT_ON on the next edge, with the counter cleared.
REQ-016 Latency: led_n SHALL fall on the first clock edge after the strobe cycle.
REQ-017 HIT_ON SHALL last exactly HIT_CYCLES cycles, then enter IDLE.
REQ-018 A hit during HIT_ON SHALL clear the counter (retrigger), extending the on time to HIT_CYCLES cycles from that strobe.
REQ-019 A miss during HIT_ON SHALL abort the hit and enter MISS_ON, with the counter and blink count cleared.
REQ-020 MISS_ON SHALL last BLINK_CYCLES cycles, then enter MISS_OFF; MISS_OFF SHALL last BLINK_CYCLES cycles, then increment the blink count.
REQ-021 After MISS_OFF, if the blink count reaches MISS_BLINKS the block SHALL enter IDLE; otherwise it SHALL return to MISS_ON.
REQ-022 hit SHALL be ignored in MISS_ON and MISS_OFF.
REQ-023 A miss in MISS_ON or MISS_OFF SHALL restart the sequence at MISS_ON with the counter and blink count cleared.
REQ-024 Simultaneous hit and miss in any state SHALL be treated as miss only.
REQ-025 done SHALL pulse high for exactly one cycle, on the same edge that the state becomes IDLE by normal completion.
REQ-026 done SHALL NOT pulse on abort, on retrigger, or on reset.
REQ-027 The counter SHALL never wrap: it is compared against (duration-1) and cleared on every state change.
REQ-028 A strobe arriving on the same cycle that the block completes to IDLE SHALL be accepted by the IDLE rules on the following cycle; the strobe is lost only if it was asserted for the completion cycle alone.

Reset
REQ-029 While rst_n = 0 the block SHALL be in IDLE with led_n = 1, busy = 0, done = 0, and the counter and blink count at 0, independent of clk.
REQ-030 Assertion of rst_n mid-indication SHALL immediately extinguish the LED and discard all progress.
REQ-031 After rst_n deasserts, the block SHALL accept a strobe on the first clock edge.

Verification (HIT_CYCLES=4, BLINK_CYCLES=2, MISS_BLINKS=2)
REQ-032 Reset then hit pulse at cycle 0 -> led_n=0 for cycles 1-4; led_n=1, busy=0 and done=1 at cycle 5.
REQ-033 Hit at cycle 0, second hit at cycle 2 -> led_n=0 for cycles 1-6; single done pulse at cycle 7.
REQ-034 Miss at cycle 0 -> led_n pattern 0,0,1,1,0,0,1,1 over cycles 1-8; done=1 at cycle 9.
REQ-035 Hit and miss asserted in the same cycle -> miss blink pattern per REQ-034; no hit behaviour.
REQ-036 Hit at cycle 0, miss at cycle 2 -> led_n=0 for cycles 1-2, then miss pattern starting at cycle 3; no done pulse before cycle 11.
REQ-037 Miss at cycle 0, rst_n low at cycle 3 -> led_n=1 and busy=0 immediately; no done pulse; a hit after release behaves per REQ-032.

Source files
------------

// File: rtl/led_feedback_driver_if.sv
// led_feedback_driver_if
//   Bundles the strobe inputs and the LED/status outputs of the LED
//   feedback driver so they travel as a single port.
//   hit   : single-cycle strobe requesting a hit indication
//   miss  : single-cycle strobe requesting a miss indication
//   led_n : active-low LED drive (0 = lit)
//   busy  : high while an indication is in progress
//   done  : one-cycle pulse when an indication completes normally
//   slave  modport : the driver (consumes strobes, produces status)
//   master modport : the requester (issues strobes, observes status)
interface led_feedback_driver_if;
    logic hit;
    logic miss;
    logic led_n;
    logic busy;
    logic done;

    modport slave  (input  hit, input  miss, output led_n, output busy, output done);
    modport master (output hit, output miss, input  led_n, input  busy, input  done);
endinterface

// File: rtl/led_feedback_driver.sv
// led_feedback_driver
//   Drives an active-low LED to give feedback on hit/miss events:
//   a hit lights the LED solidly for HIT_CYCLES cycles (retriggerable),
//   a miss blinks it MISS_BLINKS times with BLINK_CYCLES on and off phases.
//   A miss always takes priority over a hit.
// Ports
//   clk   : clock, all logic on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : led_feedback_driver_if.slave (hit, miss in; led_n, busy, done out)
module led_feedback_driver #(
    parameter int CNT_W        = 16,
    parameter int HIT_CYCLES   = 65535,
    parameter int BLINK_CYCLES = 16384,
    parameter int MISS_BLINKS  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_feedback_driver_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIT_ON   = 2'd1,
        MISS_ON  = 2'd2,
        MISS_OFF = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [3:0]       BLINKS     = 4'(MISS_BLINKS);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [3:0]       r_blinks, w_blinks_next;
    logic             w_done_next;
    logic             r_led_n, r_busy, r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_blinks <= '0;
            r_led_n  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_blinks <= w_blinks_next;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state itself.
            r_led_n  <= !((w_state_next == HIT_ON) || (w_state_next == MISS_ON));
            r_busy   <= (w_state_next != IDLE);
            r_done   <= w_done_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt + 1'b1;
        w_blinks_next = r_blinks;
        w_done_next   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next    = '0;
                w_blinks_next = '0;
                if (bus.miss) begin
                    w_state_next = MISS_ON;
                end else if (bus.hit) begin
                    w_state_next = HIT_ON;
                end
            end
            HIT_ON: begin
                // Completion wins over a strobe in the final cycle; a strobe
                // held one cycle longer is then picked up from IDLE.
                if (r_cnt == HIT_LAST) begin
                    w_state_next  = IDLE;
                    w_cnt_next    = '0;
                    w_done_next   = 1'b1;
                end else if (bus.miss) begin
                    w_state_next  = MISS_ON;
                    w_cnt_next    = '0;
                    w_blinks_next = '0;
                end else if (bus.hit) begin
                    w_cnt_next    = '0;
                end
            end
            MISS_ON: begin
                if (bus.miss) begin
                    w_cnt_next    = '0;
                    w_blinks_next = '0;
                end else if (r_cnt == BLINK_LAST) begin
                    w_state_next  = MISS_OFF;
                    w_cnt_next    = '0;
                end
            end
            MISS_OFF: begin
                if ((r_cnt == BLINK_LAST) && ((r_blinks + 4'd1) == BLINKS)) begin
                    w_state_next  = IDLE;
                    w_cnt_next    = '0;
                    w_blinks_next = '0;
                    w_done_next   = 1'b1;
                end else if (bus.miss) begin
                    w_state_next  = MISS_ON;
                    w_cnt_next    = '0;
                    w_blinks_next = '0;
                end else if (r_cnt == BLINK_LAST) begin
                    w_state_next  = MISS_ON;
                    w_cnt_next    = '0;
                    w_blinks_next = r_blinks + 4'd1;
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_cnt_next    = '0;
                w_blinks_next = '0;
            end
        endcase
    end

    assign bus.led_n = r_led_n;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_led_feedback_driver.sv
// tb_led_feedback_driver
//   Directed per-cycle vectors for the LED feedback driver with
//   HIT_CYCLES=4, BLINK_CYCLES=2, MISS_BLINKS=2. Each vector string holds
//   one character per cycle (leftmost = cycle 0). The stimulus process
//   drives inputs and queues the expected outputs for that cycle; the
//   monitor pops and compares on the falling edge.
module tb_led_feedback_driver;

    logic clk;
    logic rst_n;

    led_feedback_driver_if bus ();

    led_feedback_driver #(
        .CNT_W       (16),
        .HIT_CYCLES  (4),
        .BLINK_CYCLES(2),
        .MISS_BLINKS (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        string name;
        logic  led_n;
        logic  busy;
        logic  done;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic on(input string s, input int k);
        if (k >= s.len()) return 1'b0;
        return (s.getc(k) == 8'h31);
    endfunction

    task automatic run_seq(input string name, input string rst, input string hit,
                           input string miss, input string led, input string busy,
                           input string done);
        exp_t e;
        for (int k = 0; k < led.len(); k++) begin
            @(posedge clk);
            #1;
            rst_n    = !on(rst, k);
            bus.hit  = on(hit, k);
            bus.miss = on(miss, k);
            e.name   = $sformatf("%s.c%0d", name, k);
            e.led_n  = on(led, k);
            e.busy   = on(busy, k);
            e.done   = on(done, k);
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic ok;
            e  = q.pop_front();
            ok = 1'b1;
            n_checks = n_checks + 3;
            if (bus.led_n !== e.led_n) begin
                n_fail = n_fail + 1; ok = 1'b0;
                $display("FAIL %s led_n: got %b expected %b", e.name, bus.led_n, e.led_n);
            end
            if (bus.busy !== e.busy) begin
                n_fail = n_fail + 1; ok = 1'b0;
                $display("FAIL %s busy: got %b expected %b", e.name, bus.busy, e.busy);
            end
            if (bus.done !== e.done) begin
                n_fail = n_fail + 1; ok = 1'b0;
                $display("FAIL %s done: got %b expected %b", e.name, bus.done, e.done);
            end
            if (ok)
                $display("ok   %s led_n=%b busy=%b done=%b", e.name, bus.led_n, bus.busy, bus.done);
        end
    end

    initial begin
        int budget;
        rst_n    = 1'b0;
        bus.hit  = 1'b0;
        bus.miss = 1'b0;

        // Reset state, with a hit strobe that must be ignored while in reset.
        run_seq("reset",  "11", "10", "00", "11", "00", "00");
        // Single hit: lit cycles 1-4, done at 5.
        run_seq("hit",    "", "1000000", "", "1000011", "0111100", "0000010");
        // Retrigger at cycle 2: lit cycles 1-6, single done at 7.
        run_seq("retrig", "", "101000000", "", "100000011", "011111100", "000000010");
        // Miss: two blink pairs over cycles 1-8, done at 9.
        run_seq("miss",   "", "", "10000000000", "10011001111", "01111111100", "00000000010");
        // Simultaneous hit and miss behaves as miss only.
        run_seq("both",   "", "10000000000", "10000000000",
                "10011001111", "01111111100", "00000000010");
        // Miss aborts a hit at cycle 2: blinks from cycle 3, done at 11 only.
        run_seq("abort",  "", "1000000000000", "0010000000000",
                "1000011001111", "0111111111100", "0000000000010");
        // Hit ignored during the blink; miss at cycle 4 restarts from cycle 5.
        run_seq("restart", "", "001000000000000", "100010000000000",
                "100110011001111", "011111111111100", "000000000000010");
        // Reset mid-blink kills the LED at once; hit right after release works.
        run_seq("rstmid", "000110000000", "000001000000", "100000000000",
                "100111000011", "011000111100", "000000000010");

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL drain: %0d expected vectors left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
